// File: rtl/ifetch_unit.sv
// Instruction fetch sequencer for the multi-cycle CPU.
// Owns the PC. Fetches the instruction at pc over a req/ack memory handshake
// and hands the word to the instruction register with a one-cycle strobe.
// PC redirects that arrive during a fetch are held and applied when it completes.
// If memory never acks, a timeout moves the unit into a sticky fault state.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   fetch                 one-cycle fetch request from the control FSM
//   pc_wr, pc_next        PC redirect strobe and target (bits [1:0] forced to 0)
//   imem_req, imem_addr   memory read request and address
//   imem_ack, imem_rdata  memory read data valid and data
//   ir_en, ir_data        one-cycle IR write strobe and instruction word
//   pc, pc_plus           next fetch address; last fetched address + PC_STEP
//   busy, fault           fetch in progress; sticky memory-timeout flag
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch,
  input  logic        pc_wr,
  input  logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ir_en,
  output logic [31:0] ir_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus,
  output logic        busy,
  output logic        fault
);

  typedef enum logic [1:0] {StIdle, StBus, StFault} state_t;

  localparam logic [7:0]  TimerMax = 8'(TIMEOUT - 1);
  localparam logic [31:0] Step     = 32'(PC_STEP);

  state_t      state;
  logic [7:0]  timer;
  logic        pend_valid;
  logic [31:0] pend_pc;

  logic [31:0] wr_target;
  logic [31:0] eff_pc;
  logic [31:0] next_seq;

  assign wr_target = {pc_next[31:2], 2'b00};
  // A redirect in the same cycle as fetch steers that fetch.
  assign eff_pc    = pc_wr ? wr_target : pc;
  // Wraps modulo 2^32 by construction.
  assign next_seq  = imem_addr + Step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      pc         <= RESET_PC;
      imem_addr  <= RESET_PC;
      imem_req   <= 1'b0;
      ir_en      <= 1'b0;
      ir_data    <= 32'h0;
      pc_plus    <= 32'h0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      timer      <= 8'h0;
      pend_valid <= 1'b0;
      pend_pc    <= 32'h0;
    end else begin
      ir_en <= 1'b0;
      unique case (state)
        StIdle: begin
          if (pc_wr) pc <= wr_target;
          if (fetch) begin
            imem_addr <= eff_pc;
            imem_req  <= 1'b1;
            busy      <= 1'b1;
            timer     <= 8'h0;
            state     <= StBus;
          end
        end
        StBus: begin
          if (imem_ack) begin
            ir_data  <= imem_rdata;
            ir_en    <= 1'b1;
            pc_plus  <= next_seq;
            // A redirect arriving with the ack is the most recent write.
            if (pc_wr)           pc <= wr_target;
            else if (pend_valid) pc <= pend_pc;
            else                 pc <= next_seq;
            pend_valid <= 1'b0;
            imem_req   <= 1'b0;
            busy       <= 1'b0;
            state      <= StIdle;
          end else if (timer == TimerMax) begin
            imem_req   <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b1;
            pend_valid <= 1'b0;
            state      <= StFault;
          end else begin
            timer <= timer + 8'h1;
            if (pc_wr) begin
              pend_valid <= 1'b1;
              pend_pc    <= wr_target;
            end
          end
        end
        StFault: ;  // absorbing until reset
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a period away from the active edge.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch;
  logic        pc_wr;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ir_en;
  logic [31:0] ir_data;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic        busy;
  logic        fault;

  int checks = 0;
  int errors = 0;

  ifetch_unit #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch     (fetch),
    .pc_wr     (pc_wr),
    .pc_next   (pc_next),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .ir_en     (ir_en),
    .ir_data   (ir_data),
    .pc        (pc),
    .pc_plus   (pc_plus),
    .busy      (busy),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch = 1'b0; pc_wr = 1'b0; pc_next = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({imem_req, ir_en, busy, fault} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got req/ir_en/busy/fault=%b required 0000",
               {imem_req, ir_en, busy, fault});
    end
    checks++;
    if ({pc, imem_addr, ir_data, pc_plus} !== 128'h0) begin
      errors++;
      $display("FAIL reset_words: got pc=%h addr=%h ir=%h pc_plus=%h required all 0",
               pc, imem_addr, ir_data, pc_plus);
    end
  endtask

  task automatic test_zero_wait();
    // ack already high when fetch is sampled in IDLE; it must be ignored there
    fetch = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    tick();
    fetch = 1'b0;
    checks++;
    if ({imem_req, busy, ir_en} !== 3'b110 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL zw_req: got req/busy/ir_en=%b addr=%h required 110 addr=0",
               {imem_req, busy, ir_en}, imem_addr);
    end
    tick();
    imem_ack = 1'b0;
    checks++;
    if ({ir_en, busy, imem_req} !== 3'b100 || ir_data !== 32'h2008_0005) begin
      errors++;
      $display("FAIL zw_ir: got ir_en/busy/req=%b ir=%h required 100 ir=20080005",
               {ir_en, busy, imem_req}, ir_data);
    end
    checks++;
    if (pc !== 32'h4 || pc_plus !== 32'h4) begin
      errors++;
      $display("FAIL zw_pc: got pc=%h pc_plus=%h required 4 4", pc, pc_plus);
    end
    tick();
    checks++;
    if (ir_en !== 1'b0 || ir_data !== 32'h2008_0005) begin
      errors++;
      $display("FAIL zw_pulse: got ir_en=%b ir=%h required 0 20080005", ir_en, ir_data);
    end
  endtask

  task automatic test_wait_back_to_back();
    logic [31:0] exp_addr;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    for (int f = 0; f < 2; f++) begin
      exp_addr = 32'h4 + 32'(4 * f);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({imem_req, busy, ir_en} !== 3'b110 || imem_addr !== exp_addr) begin
          errors++;
          $display("FAIL wait_hold f%0d c%0d: got req/busy/ir_en=%b addr=%h required 110 %h",
                   f, i, {imem_req, busy, ir_en}, imem_addr, exp_addr);
        end
        if (i == 3) begin
          imem_ack = 1'b1; imem_rdata = 32'hA000_0000 + exp_addr;
        end
        tick();
      end
      imem_ack = 1'b0;
      checks++;
      if (ir_en !== 1'b1 || ir_data !== 32'hA000_0000 + exp_addr || pc !== exp_addr + 32'h4) begin
        errors++;
        $display("FAIL wait_done f%0d: got ir_en=%b ir=%h pc=%h required 1 %h %h",
                 f, ir_en, ir_data, pc, 32'hA000_0000 + exp_addr, exp_addr + 32'h4);
      end
      if (f == 0) begin
        fetch = 1'b1;  // accepted during the ir_en cycle
        tick();
        fetch = 1'b0;
      end
    end
    checks++;
    if (pc !== 32'hC) begin
      errors++;
      $display("FAIL b2b_pc: got %h required 0000000c", pc);
    end
    tick();
  endtask

  task automatic test_redirect();
    pc_wr = 1'b1; pc_next = 32'h0000_0103; fetch = 1'b1;
    tick();
    pc_wr = 1'b0; fetch = 1'b0;
    checks++;
    if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL redir_addr: got addr=%h req=%b required 100 1", imem_addr, imem_req);
    end
    imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
    tick();
    imem_ack = 1'b0;
    checks++;
    if (pc !== 32'h104 || pc_plus !== 32'h104 || ir_en !== 1'b1) begin
      errors++;
      $display("FAIL redir_pc: got pc=%h pc_plus=%h ir_en=%b required 104 104 1",
               pc, pc_plus, ir_en);
    end
    // mid-BUS redirects: last one wins, in-flight address untouched
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    pc_wr = 1'b1; pc_next = 32'h0000_0200;
    tick();
    pc_next = 32'h0000_0400;
    tick();
    pc_wr = 1'b0;
    checks++;
    if (imem_addr !== 32'h104 || imem_req !== 1'b1 || pc !== 32'h104) begin
      errors++;
      $display("FAIL redir_inflight: got addr=%h req=%b pc=%h required 104 1 104",
               imem_addr, imem_req, pc);
    end
    imem_ack = 1'b1; imem_rdata = 32'h3333_4444;
    tick();
    imem_ack = 1'b0;
    checks++;
    if (pc !== 32'h400 || pc_plus !== 32'h108 || ir_data !== 32'h3333_4444) begin
      errors++;
      $display("FAIL redir_pending: got pc=%h pc_plus=%h ir=%h required 400 108 33334444",
               pc, pc_plus, ir_data);
    end
    tick();
  endtask

  task automatic test_wrap();
    pc_wr = 1'b1; pc_next = 32'hFFFF_FFFF;
    tick();
    pc_wr = 1'b0;
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_set: got pc=%h required fffffffc", pc);
    end
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
    tick();
    imem_ack = 1'b0;
    checks++;
    if (pc !== 32'h0 || pc_plus !== 32'h0 || ir_en !== 1'b1) begin
      errors++;
      $display("FAIL wrap: got pc=%h pc_plus=%h ir_en=%b required 0 0 1", pc, pc_plus, ir_en);
    end
    tick();
  endtask

  task automatic test_reset_mid_fetch();
    pc_wr = 1'b1; pc_next = 32'h0000_0080;
    tick();
    pc_wr = 1'b0;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    tick();            // now in the 2nd wait cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({imem_req, busy, ir_en} !== 3'b000 || pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: got req/busy/ir_en=%b pc=%h required 000 0",
               {imem_req, busy, ir_en}, pc);
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (ir_en !== 1'b0 || ir_data !== 32'h0 || pc !== 32'h0) begin
        errors++;
        $display("FAIL late_ack c%0d: got ir_en=%b ir=%h pc=%h required 0 0 0",
                 i, ir_en, ir_data, pc);
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int ir_pulses = 0;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (imem_req !== 1'b1 || fault !== 1'b0) begin
        errors++;
        $display("FAIL to_wait c%0d: got req=%b fault=%b required 1 0", i, imem_req, fault);
      end
      if (i == 3) begin
        pc_wr = 1'b1; pc_next = 32'h0000_0800;
      end else begin
        pc_wr = 1'b0;
      end
      tick();
      if (ir_en) ir_pulses++;
    end
    checks++;
    if ({imem_req, busy, fault} !== 3'b001 || pc !== 32'h0 || ir_pulses != 0) begin
      errors++;
      $display("FAIL to_fault: got req/busy/fault=%b pc=%h ir_pulses=%0d required 001 0 0",
               {imem_req, busy, fault}, pc, ir_pulses);
    end
    fetch = 1'b1; pc_wr = 1'b1; pc_next = 32'h0000_0900;
    tick();
    fetch = 1'b0; pc_wr = 1'b0;
    tick();
    checks++;
    if ({imem_req, busy, fault} !== 3'b001 || pc !== 32'h0) begin
      errors++;
      $display("FAIL to_absorb: got req/busy/fault=%b pc=%h required 001 0",
               {imem_req, busy, fault}, pc);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (fault !== 1'b0 || pc !== 32'h0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL to_reset: got fault=%b pc=%h addr=%h required 0 0 0", fault, pc, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_back_to_back();
    test_redirect();
    test_wrap();
    test_reset_mid_fetch();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
